// File: rtl/jtag_pkg.sv
// Shared TAP state encoding, default opcodes, IR capture pattern and decode structs.
// Pure declarations: no logic, no latency, no backpressure.
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_EX2_DR   = 4'h0,
        TAP_EX1_DR   = 4'h1,
        TAP_SH_DR    = 4'h2,
        TAP_PAUSE_DR = 4'h3,
        TAP_SEL_IR   = 4'h4,
        TAP_UPD_DR   = 4'h5,
        TAP_CAP_DR   = 4'h6,
        TAP_SEL_DR   = 4'h7,
        TAP_EX2_IR   = 4'h8,
        TAP_EX1_IR   = 4'h9,
        TAP_SH_IR    = 4'hA,
        TAP_PAUSE_IR = 4'hB,
        TAP_RTI      = 4'hC,
        TAP_UPD_IR   = 4'hD,
        TAP_CAP_IR   = 4'hE,
        TAP_TLR      = 4'hF
    } tap_state_e;

    localparam int DEF_IR_SIZE          = 4;
    localparam int DEF_OP_SAMPLE_PRELOAD = 2;
    localparam int DEF_OP_INTEST        = 3;
    localparam int DEF_OP_RUNBIST       = 4;
    localparam int DEF_OP_IDCODE        = 5;
    localparam int DEF_OP_HIGHZ         = 6;

    // Low two bits of the Capture-IR value; upper bits are zero.
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

    typedef struct packed {
        logic tlr;
        logic rti;
        logic cap_ir;
        logic sh_ir;
        logic upd_ir;
        logic cap_dr;
        logic sh_dr;
        logic upd_dr;
    } tap_strobe_t;

    typedef struct packed {
        logic bsc;
        logic id;
        logic byp;
        logic mode;
        logic highz;
    } dr_sel_t;

endpackage

// File: rtl/jtag_tap_ir_decoder_if.sv
// Test-pin side and data-register side signals of the TAP/IR decoder.
// slave = TAP block, master = pins plus data registers driving it.
interface jtag_tap_ir_decoder_if
    import jtag_pkg::*;
#(
    parameter int IR_SIZE = DEF_IR_SIZE
);
    logic               tms;
    logic               tdi;
    logic               bsc_tdo;
    logic               byp_tdo;
    logic               id_tdo;
    logic               tdo;
    logic               tdo_en;
    logic               mode;
    logic               highz;
    logic               bsc_capture_en;
    logic               bsc_shift_en;
    logic               bsc_update_en;
    logic               byp_shift_en;
    logic               id_capture_en;
    logic               id_shift_en;
    logic               bist_start;
    logic [IR_SIZE-1:0] instruction;

    modport master (
        output tms, tdi, bsc_tdo, byp_tdo, id_tdo,
        input  tdo, tdo_en, mode, highz, bsc_capture_en, bsc_shift_en,
               bsc_update_en, byp_shift_en, id_capture_en, id_shift_en,
               bist_start, instruction
    );

    modport slave (
        input  tms, tdi, bsc_tdo, byp_tdo, id_tdo,
        output tdo, tdo_en, mode, highz, bsc_capture_en, bsc_shift_en,
               bsc_update_en, byp_shift_en, id_capture_en, id_shift_en,
               bist_start, instruction
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller advancing on tms every clock; state strobes decoded from state.
// One state per clock, no backpressure; tlr_nxt flags that the next state is Test-Logic-Reset.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic        clock,
    input  logic        reset_b,
    input  logic        tms,
    output tap_strobe_t strb,
    output logic        tlr_nxt
);
    tap_state_e state_q, state_d;

    always_ff @(posedge clock) begin
        if (!reset_b) state_q <= TAP_TLR;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:      state_d = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      state_d = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:    state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR:   state_d = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_d = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   state_d = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   state_d = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:    state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR:   state_d = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_d = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   state_d = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR : TAP_RTI;
            default:      state_d = TAP_TLR;
        endcase
    end

    always_comb begin
        strb        = '0;
        strb.tlr    = (state_q == TAP_TLR);
        strb.rti    = (state_q == TAP_RTI);
        strb.cap_ir = (state_q == TAP_CAP_IR);
        strb.sh_ir  = (state_q == TAP_SH_IR);
        strb.upd_ir = (state_q == TAP_UPD_IR);
        strb.cap_dr = (state_q == TAP_CAP_DR);
        strb.sh_dr  = (state_q == TAP_SH_DR);
        strb.upd_dr = (state_q == TAP_UPD_DR);
    end

    assign tlr_nxt = (state_d == TAP_TLR);

endmodule

// File: rtl/jtag_tap_ir_decoder.sv
// TAP controller + instruction register + decoder; DR enables and tdo are combinational, instruction updates leaving Upd-IR.
// No backpressure. JTAG_IDCODE_EN enables the ID register path (otherwise IDCODE decodes to bypass).
module jtag_tap_ir_decoder
    import jtag_pkg::*;
#(
    parameter int                 IR_SIZE           = DEF_IR_SIZE,
    parameter logic [IR_SIZE-1:0] OP_EXTEST         = '0,
    parameter logic [IR_SIZE-1:0] OP_SAMPLE_PRELOAD = IR_SIZE'(DEF_OP_SAMPLE_PRELOAD),
    parameter logic [IR_SIZE-1:0] OP_INTEST         = IR_SIZE'(DEF_OP_INTEST),
    parameter logic [IR_SIZE-1:0] OP_RUNBIST        = IR_SIZE'(DEF_OP_RUNBIST),
    parameter logic [IR_SIZE-1:0] OP_IDCODE         = IR_SIZE'(DEF_OP_IDCODE),
    parameter logic [IR_SIZE-1:0] OP_HIGHZ          = IR_SIZE'(DEF_OP_HIGHZ),
    parameter logic [IR_SIZE-1:0] OP_BYPASS         = '1
)(
    input  logic                 clock,
    input  logic                 reset_b,
    jtag_tap_ir_decoder_if.slave ifc
);
`ifdef JTAG_IDCODE_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    localparam logic [IR_SIZE-1:0] OP_RESET   = ID_EN ? OP_IDCODE : OP_BYPASS;
    localparam logic [IR_SIZE-1:0] IR_CAPTURE = IR_SIZE'(IR_CAPTURE_LSBS);

    tap_strobe_t        strb;
    logic               tlr_nxt;
    logic [IR_SIZE-1:0] ir_shift_q, ir_shift_d;
    logic [IR_SIZE-1:0] instruction_q, instruction_d;
    logic               upd_seen_q, upd_seen_d;
    dr_sel_t            sel;
    logic               tdo_mux;

    jtag_tap_fsm u_fsm (
        .clock   (clock),
        .reset_b (reset_b),
        .tms     (ifc.tms),
        .strb    (strb),
        .tlr_nxt (tlr_nxt)
    );

    // Without the ID register, IDCODE falls through to bypass like any undefined opcode.
    function automatic dr_sel_t decode_op(input logic [IR_SIZE-1:0] op);
        dr_sel_t s;
        s.bsc   = (op == OP_EXTEST) || (op == OP_INTEST) || (op == OP_SAMPLE_PRELOAD);
        s.id    = ID_EN && (op == OP_IDCODE);
        s.byp   = !s.bsc && !s.id;
        s.mode  = (op == OP_EXTEST) || (op == OP_INTEST);
        s.highz = (op == OP_HIGHZ);
        return s;
    endfunction

    always_comb begin
        ir_shift_d    = ir_shift_q;
        instruction_d = instruction_q;
        upd_seen_d    = strb.upd_ir | strb.upd_dr;

        if (strb.tlr || strb.cap_ir) ir_shift_d = IR_CAPTURE;
        else if (strb.sh_ir)         ir_shift_d = {ifc.tdi, ir_shift_q[IR_SIZE-1:1]};

        // Entering TLR by any path reloads the default instruction on that same edge.
        if (tlr_nxt)          instruction_d = OP_RESET;
        else if (strb.upd_ir) instruction_d = ir_shift_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_b) begin
            ir_shift_q    <= IR_CAPTURE;
            instruction_q <= OP_RESET;
            upd_seen_q    <= 1'b0;
        end else begin
            ir_shift_q    <= ir_shift_d;
            instruction_q <= instruction_d;
            upd_seen_q    <= upd_seen_d;
        end
    end

    assign sel = decode_op(instruction_q);

    always_comb begin
        tdo_mux = 1'b0;
        if (strb.sh_ir) begin
            tdo_mux = ir_shift_q[0];
        end else if (strb.sh_dr) begin
            if (sel.bsc)     tdo_mux = ifc.bsc_tdo;
            else if (sel.id) tdo_mux = ifc.id_tdo;
            else             tdo_mux = ifc.byp_tdo;
        end
    end

    assign ifc.tdo            = tdo_mux;
    assign ifc.tdo_en         = strb.sh_ir | strb.sh_dr;
    assign ifc.mode           = sel.mode;
    assign ifc.highz          = sel.highz;
    assign ifc.instruction    = instruction_q;
    assign ifc.bsc_capture_en = strb.cap_dr & sel.bsc;
    assign ifc.bsc_shift_en   = strb.sh_dr  & sel.bsc;
    assign ifc.bsc_update_en  = strb.upd_dr & sel.bsc;
    assign ifc.byp_shift_en   = strb.sh_dr  & sel.byp;
    assign ifc.id_capture_en  = strb.cap_dr & sel.id;
    assign ifc.id_shift_en    = strb.sh_dr  & sel.id;
    assign ifc.bist_start     = strb.rti & upd_seen_q & (instruction_q == OP_RUNBIST);

endmodule
